wb_slave_pipe_regfile: RTL

Parametrised, pipelined Wishbone B4 slave register file; next generation of the `wb_slave` core. It adds byte selects, a request queue with `stall_o` back-pressure, programmable wait states and a generalised register count. It sits behind the Wishbone master/interconnect and is driven by the same interface-based bench as `wb_slave`.

---
 rtl/wb_core_2_pkg.sv | 24 ++
 rtl/wb_req_fifo.sv | 55 +++++
 rtl/wb_slave_pipe_regfile.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_core_2_pkg.sv
// rtl/wb_core_2_pkg.sv - shared types and widths for the pipelined Wishbone register file
// The request struct is sized from the package widths; the top level defaults to the same values.
package wb_core_2_pkg;

  localparam int PKG_ADDR_WIDTH = 16;
  localparam int PKG_DATA_WIDTH = 32;
  localparam int PKG_GRANULE    = 8;
  localparam int SEL_WIDTH      = PKG_DATA_WIDTH / PKG_GRANULE;
  localparam int IDX_WIDTH      = PKG_ADDR_WIDTH - $clog2(SEL_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_e;

  typedef struct packed {
    logic                      we;
    logic [IDX_WIDTH-1:0]      idx;
    logic [PKG_DATA_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0]      sel;
  } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// rtl/wb_req_fifo.sv - synchronous request queue with flush, full/empty and occupancy count
module wb_req_fifo
  import wb_core_2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  wb_req_t                i_wdata,
  output wb_req_t                o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t        r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_slave_pipe_regfile.sv
// rtl/wb_slave_pipe_regfile.sv - pipelined Wishbone slave register file with queued requests
// Define WB_SLV_ADDR_ERR_EN to answer out-of-range indices with err_o instead of aliasing.
module wb_slave_pipe_regfile
  import wb_core_2_pkg::*;
#(
  parameter int ADDR_WIDTH   = PKG_ADDR_WIDTH,
  parameter int DATA_WIDTH   = PKG_DATA_WIDTH,
  parameter int GRANULE      = PKG_GRANULE,
  parameter int REGISTER_NUM = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int RIDX_W = $clog2(REGISTER_NUM);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LSB    = $clog2(SEL_WIDTH);

  wb_req_t                 w_in;
  wb_req_t                 w_head;
  wb_req_t                 w_req;
  wb_req_t                 r_cur;
  logic                    w_full;
  logic                    w_empty;
  logic [CNT_W-1:0]        w_count;
  logic                    w_accept;
  logic                    w_abort;
  logic                    w_pop;
  logic                    w_enter_resp;
  logic                    w_oob;
  logic [RIDX_W-1:0]       w_ridx;
  logic                    w_unused_bits;
  resp_state_e             r_state;
  logic [3:0]              r_wcnt;
  logic                    r_ack;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [DATA_WIDTH-1:0]   r_regs [REGISTER_NUM];

  assign w_abort  = ~cyc_i;
  assign w_accept = cyc_i & stb_i & ~w_full;
  assign stall_o  = (w_count == CNT_W'(FIFO_DEPTH));
  assign w_in     = '{we: we_i, idx: adr_i[ADDR_WIDTH-1:LSB], dat: dat_i, sel: sel_i};

  wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (w_abort),
    .i_wdata (w_in),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // IDLE and RESP both pop, which is what makes responses back-to-back.
  assign w_pop        = (r_state != WAIT) && !w_empty && !w_abort;
  assign w_req        = (r_state == WAIT) ? r_cur : w_head;
  assign w_enter_resp = !w_abort &&
                        (((r_state == WAIT) && (r_wcnt == 4'd0)) || (w_pop && (WAIT_CYCLES == 0)));
  assign w_ridx       = w_req.idx[RIDX_W-1:0];
  assign w_unused_bits = ^{adr_i[LSB-1:0], w_req.idx};

`ifdef WB_SLV_ADDR_ERR_EN
  assign w_oob = ({1'b0, w_req.idx} >= (IDX_WIDTH+1)'(REGISTER_NUM));
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_cur   <= '0;
      for (int i = 0; i < REGISTER_NUM; i++) r_regs[i] <= '0;
    end else if (w_abort) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      if (w_pop) r_cur <= w_head;
      case (r_state)
        IDLE, RESP: begin
          if (!w_empty) begin
            r_state <= (WAIT_CYCLES > 0) ? WAIT : RESP;
            r_wcnt  <= 4'(WAIT_CYCLES - 1);
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_wcnt == 4'd0) r_state <= RESP;
          else                r_wcnt  <= r_wcnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      // Commit and read capture share this edge so queued reads see earlier writes.
      if (w_enter_resp) begin
        r_ack <= ~w_oob;
        r_err <= w_oob;
        if (w_req.we && !w_oob) begin
          for (int k = 0; k < SEL_WIDTH; k++)
            if (w_req.sel[k]) r_regs[w_ridx][k*GRANULE +: GRANULE] <= w_req.dat[k*GRANULE +: GRANULE];
        end
        if (!w_req.we && !w_oob) r_dat <= r_regs[w_ridx];
      end
    end
  end

  assign ack_o = r_ack;
  assign err_o = r_err;
  assign dat_o = r_dat;

endmodule
